// File: rtl/wb_master_pkg.sv
// ============================================================================
// Module   : wb_master_pkg
// Brief    : Shared types and defaults for the Wishbone classic initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned c_DW_DEFAULT       = 32;
    localparam int unsigned c_AW_DEFAULT       = 32;
    localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Wide enough to hold the limit itself, so the counter can saturate there.
    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_master_timeout.sv
// ============================================================================
// Module   : wb_master_timeout
// Brief    : Clear/enable bus-wait counter; flags the last permitted cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_timeout
    import wb_master_pkg::*;
#(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = timeout_cnt_w(LIMIT)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] c_SAT  = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The edge that closes the LIMIT-th enabled cycle is the expiry edge.
    assign o_expired = i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/wb_master_bridge.sv
// ============================================================================
// Module   : wb_master_bridge
// Brief    : valid/ready request -> single Wishbone classic cycle -> response.
//            Optional bus timeout abort enabled by WB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned    DW             = c_DW_DEFAULT,
    parameter int unsigned    AW             = c_AW_DEFAULT,
    parameter int unsigned    TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0]  ERR_DATA       = c_ERR_DATA_DEFAULT
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_adr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rdy_en;
    logic               r_cyc;
    logic               r_we;
    logic [AW-1:0]      r_adr;
    logic [DW-1:0]      r_dat;
    logic [DW/8-1:0]    r_sel;
    logic               r_rsp_valid;
    logic [DW-1:0]      r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_cyc_nxt;
    logic               w_we_nxt;
    logic [AW-1:0]      w_adr_nxt;
    logic [DW-1:0]      w_dat_nxt;
    logic [DW/8-1:0]    w_sel_nxt;
    logic               w_rsp_valid_nxt;
    logic [DW-1:0]      w_rsp_rdata_nxt;
    logic               w_rsp_err_nxt;

    logic               w_accept;
    logic               w_expired;

    // req_ready stays low until the first edge after reset release.
    assign req_ready = (r_state == IDLE) && r_rdy_en;
    assign busy      = (r_state != IDLE);
    assign w_accept  = req_valid && req_ready;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_timeout #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (wb_clk),
        .i_rst_n   (wb_rst_n),
        .i_clr     (w_accept),
        .i_en      (r_state == BUS),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;

    // TIMEOUT_CYCLES has no effect here; an empty guard keeps it referenced.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_sel_nxt       = r_sel;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUS;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = req_we;
                    w_adr_nxt   = req_adr;
                    w_dat_nxt   = req_wdata;
                    w_sel_nxt   = req_sel;
                end
            end
            BUS: begin
                // Ack takes priority over an expiry on the same edge.
                if (wb_ack_i) begin
                    w_state_nxt     = RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_we ? '0 : wb_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt     = RESP;
                    w_cyc_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = ERR_DATA;
                    w_rsp_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_rdy_en    <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rdy_en    <= 1'b1;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_sel       <= w_sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
// ============================================================================
// Module   : tb_wb_master_bridge
// Brief    : Directed + randomized bench for wb_master_bridge with a
//            transaction-level reference model (WB_MASTER_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_bridge;

    localparam int unsigned c_T        = 16;
    localparam logic [31:0] c_ERR_DATA = 32'hDEAD_BEEF;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic        wb_clk;
    logic        wb_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    wb_master_bridge #(
        .TIMEOUT_CYCLES (c_T)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .busy      (busy)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    // Transaction outcome: the slave answers in bus cycle waits+1 unless the
    // initiator has already given up after c_T cycles.
    function automatic exp_t model(input logic we, input logic [31:0] ack_data,
                                   input int waits, input bit no_ack);
        exp_t e;
        int   limit;
        limit = c_TO_EN ? int'(c_T) : 1_000_000;
        if (!no_ack && waits < limit) begin
            e.cyc   = 32'(waits + 1);
            e.rdata = we ? 32'h0 : ack_data;
            e.err   = 1'b0;
        end else begin
            e.cyc   = 32'(limit);
            e.rdata = c_ERR_DATA;
            e.err   = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling clock edge with the bridge idle.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int waits, input bit no_ack,
                          input logic [31:0] ack_data, input int rsp_delay,
                          input bit stray_ack, output time acc_t);
        exp_t        e;
        int          n;
        bit          hold_bad;
        bit          stall_bad;
        logic [31:0] rdata_seen;
        logic        err_seen;
        e = model(we, ack_data, waits, no_ack);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_wdata = wdata;
        req_sel   = sel;
        wb_ack_i  = stray_ack;
        wb_dat_i  = $urandom;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge wb_clk);
        acc_t = $time;
        @(negedge wb_clk);
        req_valid = 1'b0;
        req_we    = $urandom;
        req_adr   = $urandom;
        req_wdata = $urandom;
        req_sel   = 4'($urandom);
        wb_ack_i  = 1'b0;
        check("cyc_stb_after_accept", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        check("wb_adr", wb_adr_o, adr);
        check("wb_we_dat_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, we, sel});
        check("wb_dat", wb_dat_o, wb_dat_o === wdata ? wdata : wdata);
        check("bus_busy_noready", {30'd0, busy, req_ready}, 32'd2);

        n        = 0;
        hold_bad = 1'b0;
        while (wb_cyc_o === 1'b1 && n < 200) begin
            if (wb_stb_o !== 1'b1 || wb_adr_o !== adr || wb_we_o !== we ||
                wb_dat_o !== wdata || wb_sel_o !== sel || rsp_valid !== 1'b0)
                hold_bad = 1'b1;
            wb_ack_i = !no_ack && (n == waits);
            wb_dat_i = (n == waits) ? ack_data : $urandom;
            n++;
            @(posedge wb_clk);
            @(negedge wb_clk);
            wb_ack_i = 1'b0;
        end
        check("cyc_high_cycles", 32'(n), e.cyc);
        check("bus_outputs_held", {31'd0, hold_bad}, 32'd0);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("resp_stb_busy_ready", {29'd0, wb_stb_o, busy, req_ready}, 32'd2);

        rdata_seen = rsp_rdata;
        err_seen   = rsp_err;
        stall_bad  = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            req_valid = 1'b1;
            wb_ack_i  = $urandom;
            wb_dat_i  = $urandom;
            @(posedge wb_clk);
            @(negedge wb_clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata_seen || rsp_err !== err_seen ||
                req_ready !== 1'b0 || wb_cyc_o !== 1'b0)
                stall_bad = 1'b1;
        end
        req_valid = 1'b0;
        wb_ack_i  = 1'b0;
        if (rsp_delay > 0)
            check("rsp_stall_stable", {31'd0, stall_bad}, 32'd0);

        rsp_ready = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk);
        rsp_ready = 1'b0;
        check("after_rsp_valid_busy_ready", {29'd0, rsp_valid, busy, req_ready}, 32'd1);
    endtask

    initial begin
        time t0;
        time t1;
        bit  bad;
        wb_rst_n  = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_wdata = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        #1 wb_rst_n = 1'b0;

        @(negedge wb_clk);
        @(negedge wb_clk);
        check("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_busy_ready", {30'd0, busy, req_ready}, 32'd0);
        wb_rst_n = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, req_ready}, 32'd0);
        @(negedge wb_clk);

        // Zero-wait write, then a 3-wait read.
        do_txn(1'b1, 32'h3001_0004, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 0, 1'b0, t0);
        do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 0, 1'b0, t0);

        // Back-to-back zero-wait reads must run at one per three cycles.
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 0, 1'b0, 32'hCAFE_0001, 0, 1'b0, t0);
        do_txn(1'b0, 32'h3000_0014, 32'h0, 4'hC, 0, 1'b0, 32'hCAFE_0002, 0, 1'b0, t1);
        check("throughput_period_ns", 32'(t1 - t0), 32'd30);

        // Response held off 10 cycles with stray acks and requests present.
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 1'b0, 32'h5555_AAAA, 10, 1'b1, t0);

`ifdef WB_MASTER_TIMEOUT_EN
        do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 1'b1, 32'h0, 2, 1'b0, t0);
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, int'(c_T) - 1, 1'b0, 32'h7777_1111, 0, 1'b0, t0);
        do_txn(1'b1, 32'h3000_0034, 32'h1111_2222, 4'h1, int'(c_T), 1'b0, 32'h0, 0, 1'b0, t0);
`endif

        // Reset in the middle of a bus cycle abandons it without a response.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h3000_0040;
        @(posedge wb_clk);
        @(negedge wb_clk);
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
        end
        check("midbus_cyc_before_reset", {31'd0, wb_cyc_o}, 32'd1);
        wb_rst_n = 1'b0;
        #1;
        check("midbus_reset_outputs", {28'd0, wb_cyc_o, wb_stb_o, rsp_valid, busy}, 32'd0);
        check("midbus_reset_ready", {31'd0, req_ready}, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("no_rsp_after_reset", {31'd0, bad}, 32'd0);
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 2, 1'b0, 32'h9ABC_DEF0, 1, 1'b0, t0);

        // Randomized traffic.
        for (int k = 0; k < 16; k++) begin
            logic        r_we;
            int          r_waits;
            bit          r_noack;
            r_we    = 1'($urandom);
            r_noack = c_TO_EN && ($urandom_range(0, 4) == 0);
            r_waits = c_TO_EN ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 6));
            do_txn(r_we, $urandom, $urandom, 4'($urandom), r_waits, r_noack, $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom), t0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
